// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the value producer, the scan controller and the board drivers.
// The slave modport is the controller side; the master modport is the producer/observer side.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digits;
  logic                    upd;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    blank;
  logic [IDX_W-1:0]        scan_idx;
  logic                    frame_done;

  modport master (
    output digits, upd, digit_en, lz_blank,
    input  bcd_out, an, blank, scan_idx, frame_done
  );

  modport slave (
    input  digits, upd, digit_en, lz_blank,
    output bcd_out, an, blank, scan_idx, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller: one shared BCD decoder, one active-low anode per slot,
// each slot followed by an all-off guard gap; frame contents come from a per-frame snapshot.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int ON_CYCLES  = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst,
  display_scan_ctrl_if.slave bus
);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_START, ST_DRIVE, ST_GAP} state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic [IDX_W-1:0]        r_idx, w_idx_next;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_en;
  logic                    r_act_lz;
  logic                    w_load;
  logic                    w_frame_done_next;

  logic [NUM_DIGITS-1:0]   r_an, w_an_next;
  logic                    r_blank, w_blank_next;
  logic [3:0]              r_bcd, w_bcd_next;
  logic                    r_frame_done;

  // Snapshot as it will be after this edge: a load cycle with upd bypasses the shadow.
  logic [4*NUM_DIGITS-1:0] w_nv_val;
  logic [NUM_DIGITS-1:0]   w_nv_en;
  logic                    w_nv_lz;

  assign w_nv_val = w_load ? (bus.upd ? bus.digits : r_shadow) : r_act_val;
  assign w_nv_en  = w_load ? bus.digit_en : r_act_en;
  assign w_nv_lz  = w_load ? bus.lz_blank : r_act_lz;

  logic [NUM_DIGITS-1:0] w_zero;
  logic [NUM_DIGITS-1:0] w_nz_en;
  logic [NUM_DIGITS-1:0] w_supp;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_supp
      assign w_zero[gi]  = (w_nv_val[4*gi +: 4] == 4'd0);
      assign w_nz_en[gi] = w_nv_en[gi] & ~w_zero[gi];
      if (gi == 0) begin : g_lsd
        assign w_supp[gi] = ~w_nv_en[gi];
      end else begin : g_upper
        // Blanked when zero and no enabled nonzero digit sits above it.
        assign w_supp[gi] = ~w_nv_en[gi] |
                            (w_nv_lz & w_zero[gi] & ~|(w_nz_en >> (gi + 1)));
      end
    end
  endgenerate

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_idx_next        = r_idx;
    w_load            = 1'b0;
    w_frame_done_next = 1'b0;
    case (r_state)
      ST_START: begin
        w_load       = 1'b1;
        w_state_next = ST_DRIVE;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
      ST_DRIVE: begin
        if (r_cnt == ON_LAST) begin
          w_state_next = ST_GAP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = ST_DRIVE;
          w_cnt_next   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_next        = '0;
            w_load            = 1'b1;
            w_frame_done_next = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_START;
    endcase
  end

  // Outputs are computed for the upcoming cycle so they can be registered.
  always_comb begin
    w_an_next    = '1;
    w_blank_next = 1'b1;
    w_bcd_next   = r_bcd;
    if (w_state_next == ST_DRIVE) begin
      w_bcd_next = w_nv_val[{w_idx_next, 2'b00} +: 4];
      if (!w_supp[w_idx_next]) begin
        w_an_next[w_idx_next] = 1'b0;
        w_blank_next          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_START;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_act_val    <= '0;
      r_act_en     <= '0;
      r_act_lz     <= 1'b0;
      r_an         <= '1;
      r_blank      <= 1'b1;
      r_bcd        <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      if (bus.upd) begin
        r_shadow <= bus.digits;
      end
      r_act_val    <= w_nv_val;
      r_act_en     <= w_nv_en;
      r_act_lz     <= w_nv_lz;
      r_an         <= w_an_next;
      r_blank      <= w_blank_next;
      r_bcd        <= w_bcd_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign bus.an         = r_an;
  assign bus.blank      = r_blank;
  assign bus.bcd_out    = r_bcd;
  assign bus.scan_idx   = r_idx;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: a frame-level reference model queues the expected output of every cycle,
// a negedge monitor pops and compares, and also checks the anode/gap/frame-period invariants.
module tb_display_scan_ctrl;
  localparam int ND    = 4;
  localparam int ON    = 4;
  localparam int GAP   = 2;
  localparam int SLOT  = ON + GAP;
  localparam int FRAME = ND * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS(ND),
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] an;
    logic       blank;
    logic [3:0] bcd;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Model state: position within the frame for the current cycle, snapshot and shadow.
  bit          m_started = 1'b0;
  int          m_pos     = 0;
  logic [15:0] m_shadow  = '0;
  logic [15:0] m_val     = '0;
  logic [3:0]  m_en      = '0;
  logic        m_lz      = 1'b0;
  logic [3:0]  m_bcd     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic suppressed(input int s, input logic [15:0] v,
                                      input logic [3:0] en, input logic lz);
    if (!en[s]) return 1'b1;
    if (!lz || s == 0 || v[4*s +: 4] != 4'd0) return 1'b0;
    for (int j = s + 1; j < ND; j++)
      if (en[j] && v[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: runs on each edge and queues what the outputs must show next cycle.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_started = 1'b0;
        m_pos     = 0;
        m_shadow  = '0;
        m_bcd     = '0;
        exp_q.delete();
      end else begin
        exp_t e;
        bit   load;
        int   slot;
        e.fd = 1'b0;
        load = 1'b0;
        if (!m_started) begin
          m_started = 1'b1;
          m_pos     = 0;
          load      = 1'b1;
        end else begin
          m_pos++;
          if (m_pos == FRAME) begin
            m_pos = 0;
            load  = 1'b1;
            e.fd  = 1'b1;
          end
        end
        if (load) begin
          m_val = bus.upd ? bus.digits : m_shadow;
          m_en  = bus.digit_en;
          m_lz  = bus.lz_blank;
        end
        if (bus.upd) m_shadow = bus.digits;
        slot    = m_pos / SLOT;
        e.idx   = 2'(slot);
        e.an    = 4'hF;
        e.blank = 1'b1;
        if ((m_pos % SLOT) < ON) begin
          m_bcd = m_val[4*slot +: 4];
          if (!suppressed(slot, m_val, m_en, m_lz)) begin
            e.an[slot] = 1'b0;
            e.blank    = 1'b0;
          end
        end
        e.bcd = m_bcd;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: per-cycle scoreboard compare plus invariants.
  initial begin
    bit         have_drv = 1'b0;
    logic [3:0] prev_drv = 4'hF;
    int         ones_run = 0;
    bit         have_fd  = 1'b0;
    int         fd_cnt   = 0;
    int         frames   = 0;
    forever begin
      @(negedge clk);
      if (rst || !m_started) begin
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_blank", 32'(bus.blank), 32'h1);
        check("rst_bcd", 32'(bus.bcd_out), 32'h0);
        check("rst_idx", 32'(bus.scan_idx), 32'h0);
        check("rst_fd", 32'(bus.frame_done), 32'h0);
        have_drv = 1'b0;
        ones_run = 0;
        have_fd  = 1'b0;
        fd_cnt   = 0;
      end else if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd0, 32'd1);
      end else begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a = {bus.an, bus.blank, bus.bcd_out, bus.scan_idx, bus.frame_done};
        check("cycle{an,blank,bcd,idx,fd}", 32'(a), 32'(e));
        check("an_onehot0", 32'($countones(~bus.an) <= 1), 32'd1);
        if (bus.an != 4'hF) begin
          if (have_drv && bus.an != prev_drv)
            check("guard_gap", 32'(ones_run >= GAP), 32'd1);
          have_drv = 1'b1;
          prev_drv = bus.an;
          ones_run = 0;
        end else begin
          ones_run++;
        end
        fd_cnt++;
        if (bus.frame_done) begin
          if (have_fd) check("frame_period", 32'(fd_cnt), 32'(FRAME));
          frames++;
          $display("frame %0d done at %0t, period %0d cycles", frames, $time, fd_cnt);
          have_fd = 1'b1;
          fd_cnt  = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_upd(input logic [15:0] d);
    bus.digits = d;
    bus.upd    = 1'b1;
    tick(1);
    bus.upd    = 1'b0;
  endtask

  initial begin
    bit found;
    bus.digits   = '0;
    bus.upd      = 1'b0;
    bus.digit_en = 4'hF;
    bus.lz_blank = 1'b0;
    rst = 1'b1;
    tick(3);

    // Reset release straight into a START cycle that bypasses the shadow.
    rst = 1'b0;
    pulse_upd(16'h4321);

    // Mid-frame update must only show from the next frame on.
    tick(8);
    pulse_upd(16'h9876);
    tick(40);

    // Leading-zero blanking on and off.
    bus.lz_blank = 1'b1;
    pulse_upd(16'h0050);
    tick(48);
    bus.lz_blank = 1'b0;
    tick(48);

    // Enable mask combined with blanking.
    bus.digit_en = 4'b1011;
    bus.lz_blank = 1'b1;
    pulse_upd(16'h0007);
    tick(48);

    // Asynchronous reset in the middle of slot 2's drive window.
    bus.digit_en = 4'hF;
    bus.lz_blank = 1'b0;
    pulse_upd(16'h1234);
    tick(30);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (m_pos == 13) begin
        found = 1'b1;
        break;
      end
    end
    check("sync_to_slot2", 32'(found), 32'd1);
    check("pre_rst_an", 32'(bus.an), 32'hB);
    rst = 1'b1;
    #1;
    check("async_an", 32'(bus.an), 32'hF);
    check("async_blank", 32'(bus.blank), 32'h1);
    check("async_idx", 32'(bus.scan_idx), 32'h0);
    check("async_fd", 32'(bus.frame_done), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(30);

    // Random traffic over ten frames.
    for (int c = 0; c < 10 * FRAME; c++) begin
      bus.digits = 16'($urandom);
      bus.upd    = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) bus.digit_en = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) bus.lz_blank = 1'($urandom_range(1));
      tick(1);
    end
    bus.upd = 1'b0;
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
